// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard control unit.
// Produces the stall/flush/bubble controls for the PC and the FD, DX and XM
// pipeline registers. It handles load-use hazards, taken-branch redirects,
// data-memory wait states and a memory timeout. It also keeps performance
// counters for stall cycles and for the redirect flushes that are applied.
//
// Ports
//   clk, n_reset          clock; synchronous active-low reset
//   rs/rd_addr_d, uses_*  register operands of the instruction in decode
//   *_dx                  load / write-back info of the instruction in DX
//   branch_taken_x        execute resolved a taken branch or jump
//   dmem_req_m, dmem_ack  data-memory handshake
//   halt_req              a halt instruction is retiring
//   stall_*, flush_*,
//   bubble_dx             combinational pipeline controls (same-cycle response)
//   halted, mem_timeout   registered status; mem_timeout is sticky
//   stall_cycles          number of cycles with stall_pc high
//   flush_count           number of redirect flushes applied
module hazard_ctrl #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned TIMEOUT    = 64,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  n_reset,
   input  logic [REG_ADDR_W-1:0] rs_addr_d,
   input  logic [REG_ADDR_W-1:0] rd_addr_d,
   input  logic                  uses_rs_d,
   input  logic                  uses_rd_d,
   input  logic                  is_load_op_dx,
   input  logic                  op_writes_rf_dx,
   input  logic [REG_ADDR_W-1:0] dest_addr_dx,
   input  logic                  branch_taken_x,
   input  logic                  dmem_req_m,
   input  logic                  dmem_ack,
   input  logic                  halt_req,
   output logic                  stall_pc,
   output logic                  stall_fd,
   output logic                  flush_fd,
   output logic                  stall_dx,
   output logic                  flush_dx,
   output logic                  bubble_dx,
   output logic                  stall_xm,
   output logic                  halted,
   output logic                  mem_timeout,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_count
);

   localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALTED   = 2'd2
   } state_t;

   state_t              state;
   logic                pending_flush;
   logic [WAIT_W-1:0]   wait_cnt;

   logic                load_use;
   logic                mem_stall;
   logic                hold_all;
   logic                redirect;
   logic                load_stall;
   logic                halt_go;

   // Hazard detection and prioritisation: halted > memory stall > redirect > load-use > halt.
   always_comb begin
      load_use   = 1'b0;
      mem_stall  = 1'b0;
      hold_all   = 1'b0;
      redirect   = 1'b0;
      load_stall = 1'b0;
      halt_go    = 1'b0;

      // Register 0 is hard-wired, so it never creates a dependency.
      load_use = is_load_op_dx & op_writes_rf_dx & (dest_addr_dx != '0) &
                 ((uses_rs_d & (rs_addr_d == dest_addr_dx)) |
                  (uses_rd_d & (rd_addr_d == dest_addr_dx)));

      // The ack cycle of an outstanding access is the release cycle and is not stalled.
      mem_stall = ((state == ST_RUN) & dmem_req_m & ~dmem_ack) |
                  ((state == ST_MEM_WAIT) & ~dmem_ack);

      hold_all   = (state == ST_HALTED) | mem_stall;
      redirect   = ~hold_all & (branch_taken_x | pending_flush);
      load_stall = ~hold_all & ~redirect & load_use;
      halt_go    = (state == ST_RUN) & ~hold_all & ~redirect & ~load_use & halt_req;
   end

   // Pipeline control outputs, derived combinationally for a same-cycle response.
   always_comb begin
      stall_pc  = 1'b0;
      stall_fd  = 1'b0;
      stall_dx  = 1'b0;
      stall_xm  = 1'b0;
      flush_fd  = 1'b0;
      flush_dx  = 1'b0;
      bubble_dx = 1'b0;

      if (hold_all) begin
         stall_pc = 1'b1;
         stall_fd = 1'b1;
         stall_dx = 1'b1;
         stall_xm = 1'b1;
      end else if (redirect) begin
         flush_fd = 1'b1;
         flush_dx = 1'b1;
      end else if (load_stall) begin
         stall_pc  = 1'b1;
         stall_fd  = 1'b1;
         bubble_dx = 1'b1;
      end
   end

   // Control FSM, redirect replay flag, wait timer and performance counters.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state         <= ST_RUN;
         pending_flush <= 1'b0;
         wait_cnt      <= '0;
         halted        <= 1'b0;
         mem_timeout   <= 1'b0;
         stall_cycles  <= '0;
         flush_count   <= '0;
      end else begin
         if (stall_pc) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
         end
         if (redirect) begin
            flush_count <= flush_count + CNT_W'(1);
         end

         // A redirect that arrives during a memory stall is held and replayed on release.
         if (redirect) begin
            pending_flush <= 1'b0;
         end else if (mem_stall & branch_taken_x) begin
            pending_flush <= 1'b1;
         end

         case (state)
            ST_RUN: begin
               wait_cnt <= '0;
               if (mem_stall) begin
                  state <= ST_MEM_WAIT;
               end else if (halt_go) begin
                  state  <= ST_HALTED;
                  halted <= 1'b1;
               end
            end
            ST_MEM_WAIT: begin
               if (dmem_ack) begin
                  state    <= ST_RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                  state       <= ST_HALTED;
                  halted      <= 1'b1;
                  mem_timeout <= 1'b1;
                  wait_cnt    <= '0;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ST_HALTED: begin
               state    <= ST_HALTED;
               wait_cnt <= '0;
            end
            default: begin
               state    <= ST_RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

endmodule
